// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// snake_game_ctrl : IDLE/PLAY/PAUSE/OVER flow, step timer, score/level counters
// Optional macro SPEEDUP_EN : step period shortens with level (clamped).
// Revision : 1.0
// ============================================================================
module snake_game_ctrl #(
    parameter int STEP_BASE = 312500,
    parameter int STEP_DEC  = 25000,
    parameter int STEP_MIN  = 62500,
    parameter int SCORE_W   = 8,
    parameter int LVL_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               eat,
    input  logic               hit,
    output logic               step,
    output logic               clr,
    output logic               run,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [18:0]        c_per_base  = 19'(STEP_BASE);
    localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [18:0]        r_cnt;
    logic [18:0]        r_per;
    logic [18:0]        w_cnt_nxt;
    logic [18:0]        w_per_nxt;
    logic [18:0]        w_per_reload;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] w_lvl_raw;
    logic [3:0]         w_level_nxt;
    logic               w_step_nxt;
    logic               w_clr_nxt;

    // 20-bit arithmetic so the clamp is decided before any subtraction can wrap
    function automatic logic [18:0] per_for_level(input logic [3:0] lvl);
        logic [19:0] dec;
        dec = 20'(lvl) * 20'(STEP_DEC);
        if (dec + 20'(STEP_MIN) >= 20'(STEP_BASE))
            return 19'(STEP_MIN);
        else
            return 19'(20'(STEP_BASE) - dec);
    endfunction

`ifdef SPEEDUP_EN
    assign w_per_reload = per_for_level(level);
`else
    assign w_per_reload = per_for_level(4'd0);
`endif

    assign w_lvl_raw   = score >> LVL_SHIFT;
    assign w_level_nxt = w_clr_nxt ? 4'd0 :
                         (w_lvl_raw > SCORE_W'(15)) ? 4'd15 : w_lvl_raw[3:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per;
        w_score_nxt = score;
        w_step_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_start) begin
                    w_state_nxt = S_PLAY;
                    w_clr_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = c_per_base;
                    w_score_nxt = '0;
                end
            end
            S_PLAY: begin
                // collision outranks every other event, including a due step
                if (hit) begin
                    w_state_nxt = S_OVER;
                end else begin
                    if (eat && (score != c_score_max))
                        w_score_nxt = score + SCORE_W'(1);
                    if (key_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_cnt == r_per - 19'd1) begin
                        w_step_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                        w_per_nxt  = w_per_reload;
                    end else begin
                        w_cnt_nxt = r_cnt + 19'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (key_pause || key_start)
                    w_state_nxt = S_PLAY;
            end
            S_OVER: begin
                if (key_start)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_per <= c_per_base;
            score <= '0;
            level <= '0;
            step  <= 1'b0;
            clr   <= 1'b0;
            run   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_per <= w_per_nxt;
            score <= w_score_nxt;
            level <= w_level_nxt;
            step  <= w_step_nxt;
            clr   <= w_clr_nxt;
            run   <= (w_state_nxt == S_PLAY);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// Randomized scoreboard bench for snake_game_ctrl against a cycle-level game model.
module tb_snake_game_ctrl;

    localparam int STEP_BASE = 10;
    localparam int STEP_DEC  = 2;
    localparam int STEP_MIN  = 4;
    localparam int SCORE_W   = 8;
    localparam int LVL_SHIFT = 2;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_start = 1'b0, key_pause = 1'b0, eat = 1'b0, hit = 1'b0;
    logic step, clr, run;
    logic [1:0] state;
    logic [SCORE_W-1:0] score;
    logic [3:0] level;

    snake_game_ctrl #(
        .STEP_BASE(STEP_BASE), .STEP_DEC(STEP_DEC), .STEP_MIN(STEP_MIN),
        .SCORE_W(SCORE_W), .LVL_SHIFT(LVL_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_pause(key_pause),
        .eat(eat), .hit(hit), .step(step), .clr(clr), .run(run),
        .state(state), .score(score), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic [1:0]         state;
        logic               step;
        logic               clr;
        logic               run;
        logic [SCORE_W-1:0] score;
        logic [3:0]         level;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // game model: mode, cycles into current step period, period length, score, level
    int m_mode, m_ticks, m_period, m_score, m_level;

    function automatic int period_for(input int lvl);
`ifdef SPEEDUP_EN
        int p;
        p = STEP_BASE - lvl * STEP_DEC;
        return (p < STEP_MIN) ? STEP_MIN : p;
`else
        return STEP_BASE + 0 * lvl;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ticks = 0; m_period = STEP_BASE; m_score = 0; m_level = 0;
    endtask

    task automatic push_exp(input bit st, input bit cl);
        exp_t e;
        e.cyc = cyc + 1; e.state = 2'(m_mode); e.step = st; e.clr = cl;
        e.run = (m_mode == M_PLAY); e.score = SCORE_W'(m_score); e.level = 4'(m_level);
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e, input string tag);
        checks++;
        if (e.cyc != cyc || {state, step, clr, run, score, level} !==
            {e.state, e.step, e.clr, e.run, e.score, e.level}) begin
            errors++;
            $display("FAIL %s cyc=%0d(exp for %0d) got state=%0d step=%b clr=%b run=%b score=%0d level=%0d want state=%0d step=%b clr=%b run=%b score=%0d level=%0d",
                     tag, cyc, e.cyc, state, step, clr, run, score, level,
                     e.state, e.step, e.clr, e.run, e.score, e.level);
        end
    endtask

    // one clock of stimulus; the model advances by the same rules the game defines
    task automatic tick(input int ks, input int kp, input int ev, input int hv);
        bit nstep, nclr;
        int old_score, lvl_raw;
        @(posedge clk); #4;
        rst_n = 1'b1;
        key_start = (ks != 0); key_pause = (kp != 0); eat = (ev != 0); hit = (hv != 0);
        nstep = 1'b0; nclr = 1'b0;
        old_score = m_score;
        case (m_mode)
            M_IDLE: if (ks != 0) begin
                m_mode = M_PLAY; nclr = 1'b1; m_ticks = 0; m_period = STEP_BASE; m_score = 0;
            end
            M_PLAY: if (hv != 0) m_mode = M_OVER;
            else begin
                if (ev != 0 && m_score < SCORE_MAX) m_score = m_score + 1;
                if (kp != 0) m_mode = M_PAUSE;
                else begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == m_period) begin
                        nstep = 1'b1; m_ticks = 0; m_period = period_for(m_level);
                    end
                end
            end
            M_PAUSE: if (ks != 0 || kp != 0) m_mode = M_PLAY;
            default: if (ks != 0) m_mode = M_IDLE;
        endcase
        lvl_raw = old_score >> LVL_SHIFT;
        m_level = nclr ? 0 : ((lvl_raw > 15) ? 15 : lvl_raw);
        push_exp(nstep, nclr);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #4;
            rst_n = 1'b0; key_start = 0; key_pause = 0; eat = 0; hit = 0;
            model_reset();
            if (i == 0) begin
                #1;
                e.cyc = cyc; e.state = 2'd0; e.step = 0; e.clr = 0; e.run = 0;
                e.score = '0; e.level = '0;
                compare(e, "async_reset");
            end
            push_exp(1'b0, 1'b0);
        end
    endtask

    task automatic run_until_cnt(input int t);
        int k;
        k = 0;
        while (m_ticks != t && k < 100) begin
            tick(0, 0, 0, 0);
            k++;
        end
        if (m_ticks != t) begin
            checks++; errors++;
            $display("FAIL align_timeout got_cnt=%0d want_cnt=%0d", m_ticks, t);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                compare(e, "cycle");
            end
        end
    end

    initial begin : stimulus
        int b;
        model_reset();
        do_reset(3);
        repeat (8) tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        tick(1, 0, 0, 0);
        repeat (35) tick(0, 0, 0, 0);
        // pause three cycles after a step, idle noise while paused, then resume
        run_until_cnt(3);
        tick(0, 1, 0, 0);
        repeat (50) tick(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        tick(0, 1, 0, 0);
        repeat (12) tick(0, 0, 0, 0);
        repeat (6) begin
            repeat ($urandom_range(1, 15)) tick(0, 0, ($urandom_range(0, 2) == 0), 0);
            tick(0, 1, 0, 0);
            repeat ($urandom_range(0, 5)) tick(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
            b = $urandom_range(0, 1);
            tick(b, 1 - b, 0, 0);
        end
        repeat (120) tick(0, 0, $urandom_range(0, 1), 0);
        // collision coincident with eat, pause and a due step
        run_until_cnt(m_period - 1);
        tick(1, 1, 1, 1);
        repeat (5) tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        tick(1, 0, 0, 0);
        repeat (3) tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        tick(1, 0, 0, 0);
        repeat (300) tick(0, 0, 1, 0);
        repeat (5) tick(0, 0, 0, 0);
        // restart, score 3, reset mid-count
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 1, 0);
        run_until_cnt(5);
        do_reset(1);
        repeat (10) tick(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        tick(1, 0, 0, 0);
        repeat (1500) tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
        repeat (3) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain leftover=%0d want=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
